// File: rtl/dmi_handler.sv
// DMI handler: bridges the TAP DMI register to the debug module's
// request/response handshake, with timeout and dmihardreset abort.
module dmi_handler #(
  parameter  int ABITS          = 7,
  parameter  int TIMEOUT_CYCLES = 1000,
  localparam int REQW           = ABITS + 34
) (
  input  logic            CLK_I,
  input  logic            RST_I,
  input  logic            DMI_READ_I,
  input  logic            DMI_WRITE_I,
  input  logic [REQW-1:0] DMI_I,
  output logic [REQW-1:0] DMI_O,
  output logic            DMI_DONE_O,
  input  logic            DMI_HARD_RESET_I,
  output logic [1:0]      DMI_ERROR_O,
  output logic            DMI_REQ_VALID_O,
  input  logic            DMI_REQ_READY_I,
  output logic [REQW-1:0] DMI_REQ_O,
  input  logic            DMI_RESP_VALID_I,
  output logic            DMI_RESP_READY_O,
  input  logic [33:0]     DMI_RESP_I
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] OP_READ   = 2'd1;
  localparam logic [1:0] OP_WRITE  = 2'd2;
  localparam logic [1:0] RESP_BUSY = 2'd3;

  typedef struct packed {
    logic [ABITS-1:0] addr;
    logic [1:0]       op;
    logic [31:0]      data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;

  state_t    state_q, state_nxt;
  dmi_req_t  req_q, res_q;
  dmi_resp_t rsp_in;
  logic [1:0]    err_q;
  logic [CW-1:0] cnt_q;
  logic kill, to_hit, time_up;

  // The TAP op field is replaced by our own op encoding, so it is never read.
  logic unused_tap_op;
  assign unused_tap_op = ^DMI_I[33:32];

  assign rsp_in = dmi_resp_t'(DMI_RESP_I);

  // dmihardreset is treated exactly like the block reset
  assign kill = RST_I | DMI_HARD_RESET_I;

  // Timeout fires on the edge the counter would reach TIMEOUT_CYCLES; a
  // handshake completing in that same cycle wins.
  assign to_hit  = (cnt_q >= CNT_LAST);
  assign time_up = to_hit &&
                   (((state_q == S_REQ)  && !DMI_REQ_READY_I) ||
                    ((state_q == S_RESP) && !DMI_RESP_VALID_I));

  // State register
  always_ff @(posedge CLK_I) begin
    if (kill) state_q <= S_IDLE;
    else      state_q <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE: if (DMI_WRITE_I || DMI_READ_I) state_nxt = S_REQ;
      S_REQ:  if (DMI_REQ_READY_I) state_nxt = S_RESP;
              else if (time_up)   state_nxt = S_DONE;
      S_RESP: if (DMI_RESP_VALID_I || time_up) state_nxt = S_DONE;
      S_DONE: if (!DMI_READ_I && !DMI_WRITE_I) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the registered state
  always_comb begin
    DMI_REQ_VALID_O  = (state_q == S_REQ);
    DMI_RESP_READY_O = (state_q == S_RESP);
    DMI_DONE_O       = (state_q == S_DONE);
  end

  // Request latch, timeout counter and result capture
  always_ff @(posedge CLK_I) begin
    if (kill) begin
      req_q <= '0;
      res_q <= '0;
      err_q <= '0;
      cnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (DMI_WRITE_I)
            req_q <= '{addr: DMI_I[REQW-1:34], op: OP_WRITE, data: DMI_I[31:0]};
          else if (DMI_READ_I)
            req_q <= '{addr: DMI_I[REQW-1:34], op: OP_READ, data: 32'h0};
        end
        S_REQ, S_RESP: begin
          if (cnt_q < CNT_MAX) cnt_q <= cnt_q + 1'b1;
          if ((state_q == S_RESP) && DMI_RESP_VALID_I) begin
            res_q <= '{addr: req_q.addr, op: rsp_in.resp, data: rsp_in.data};
            err_q <= rsp_in.resp;
          end else if (time_up) begin
            res_q <= '{addr: req_q.addr, op: RESP_BUSY, data: 32'h0};
            err_q <= RESP_BUSY;
          end
        end
        default: ;
      endcase
    end
  end

  assign DMI_REQ_O   = req_q;
  assign DMI_O       = res_q;
  assign DMI_ERROR_O = err_q;

endmodule

// File: tb/tb_dmi_handler.sv
// Directed bench for dmi_handler: latency, stalled request, timeout,
// read/write priority, hard reset and reset aborts.
module tb_dmi_handler;
  localparam int ABITS = 7;
  localparam int REQW  = ABITS + 34;

  logic            CLK_I = 1'b0;
  logic            RST_I = 1'b1;
  logic            DMI_READ_I = 1'b0, DMI_WRITE_I = 1'b0;
  logic [REQW-1:0] DMI_I = '0;
  logic [REQW-1:0] DMI_O;
  logic            DMI_DONE_O;
  logic            DMI_HARD_RESET_I = 1'b0;
  logic [1:0]      DMI_ERROR_O;
  logic            DMI_REQ_VALID_O;
  logic            DMI_REQ_READY_I = 1'b0;
  logic [REQW-1:0] DMI_REQ_O;
  logic            DMI_RESP_VALID_I = 1'b0;
  logic            DMI_RESP_READY_O;
  logic [33:0]     DMI_RESP_I = '0;

  int checks = 0, failures = 0;

  dmi_handler #(.ABITS(ABITS), .TIMEOUT_CYCLES(16)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I),
    .DMI_READ_I(DMI_READ_I), .DMI_WRITE_I(DMI_WRITE_I),
    .DMI_I(DMI_I), .DMI_O(DMI_O), .DMI_DONE_O(DMI_DONE_O),
    .DMI_HARD_RESET_I(DMI_HARD_RESET_I), .DMI_ERROR_O(DMI_ERROR_O),
    .DMI_REQ_VALID_O(DMI_REQ_VALID_O), .DMI_REQ_READY_I(DMI_REQ_READY_I),
    .DMI_REQ_O(DMI_REQ_O), .DMI_RESP_VALID_I(DMI_RESP_VALID_I),
    .DMI_RESP_READY_O(DMI_RESP_READY_O), .DMI_RESP_I(DMI_RESP_I)
  );

  always #5 CLK_I = ~CLK_I;

  task automatic tick();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_done"},  DMI_DONE_O, 0);
    chk({tag, "_valid"}, DMI_REQ_VALID_O, 0);
    chk({tag, "_rrdy"},  DMI_RESP_READY_O, 0);
    chk({tag, "_dmio"},  DMI_O, 0);
    chk({tag, "_err"},   DMI_ERROR_O, 0);
    chk({tag, "_reqo"},  DMI_REQ_O, 0);
  endtask

  initial begin
    int n;
    tick(); tick();
    chk_reset_state("rst");
    RST_I = 1'b0;
    tick();
    chk("idle_valid", DMI_REQ_VALID_O, 0);

    // Read with READY/VALID tied high: DONE visible in the 4th cycle
    DMI_REQ_READY_I = 1; DMI_RESP_VALID_I = 1;
    DMI_RESP_I = {32'hDEADBEEF, 2'b00};
    DMI_I = {7'h11, 2'b00, 32'h12345678};
    DMI_READ_I = 1;
    tick();
    chk("rd_valid", DMI_REQ_VALID_O, 1);
    chk("rd_reqo", DMI_REQ_O, {7'h11, 2'd1, 32'h0});
    tick();
    chk("rd_rrdy", DMI_RESP_READY_O, 1);
    chk("rd_done_early", DMI_DONE_O, 0);
    tick();
    chk("rd_done", DMI_DONE_O, 1);
    chk("rd_dmio", DMI_O, {7'h11, 2'b00, 32'hDEADBEEF});
    chk("rd_err", DMI_ERROR_O, 0);
    DMI_READ_I = 0;
    tick();
    chk("rd_idle", DMI_DONE_O, 0);
    chk("rd_hold", DMI_O, {7'h11, 2'b00, 32'hDEADBEEF});

    // Write with READY held off for 5 cycles; TAP word changes mid-stall
    DMI_REQ_READY_I = 0; DMI_RESP_VALID_I = 0;
    DMI_I = {7'h10, 2'b00, 32'h1};
    DMI_WRITE_I = 1;
    tick();
    for (int i = 0; i < 6; i++) begin
      chk("wr_valid", DMI_REQ_VALID_O, 1);
      chk("wr_reqo", DMI_REQ_O, {7'h10, 2'd2, 32'h1});
      if (i == 1) DMI_I = {7'h7F, 2'b00, 32'hFFFFFFFF};
      if (i == 5) DMI_REQ_READY_I = 1;
      tick();
    end
    DMI_REQ_READY_I = 0;
    chk("wr_valid_drop", DMI_REQ_VALID_O, 0);
    chk("wr_rrdy", DMI_RESP_READY_O, 1);
    tick();
    chk("wr_wait_resp", DMI_DONE_O, 0);
    DMI_RESP_I = {32'hCAFE0001, 2'b00};
    DMI_RESP_VALID_I = 1;
    tick();
    DMI_RESP_VALID_I = 0;
    chk("wr_done", DMI_DONE_O, 1);
    chk("wr_dmio", DMI_O, {7'h10, 2'b00, 32'hCAFE0001});
    tick(); tick(); tick();
    chk("wr_done_hold", DMI_DONE_O, 1);
    DMI_WRITE_I = 0;
    tick();
    chk("wr_idle", DMI_DONE_O, 0);

    // Timeout: no response, DONE 16 cycles after entering REQ
    DMI_REQ_READY_I = 1; DMI_RESP_VALID_I = 0;
    DMI_I = {7'h22, 2'b00, 32'h0};
    DMI_READ_I = 1;
    tick();
    n = 0;
    while (!DMI_DONE_O && n < 40) begin
      tick();
      n++;
    end
    chk("to_latency", n, 16);
    chk("to_err", DMI_ERROR_O, 3);
    chk("to_dmio", DMI_O, {7'h22, 2'b11, 32'h0});
    chk("to_valid", DMI_REQ_VALID_O, 0);
    chk("to_rrdy", DMI_RESP_READY_O, 0);
    DMI_READ_I = 0;
    tick();

    // Response in the same cycle as the timeout wins
    DMI_I = {7'h33, 2'b00, 32'h0};
    DMI_READ_I = 1;
    tick();
    for (int i = 0; i < 15; i++) tick();
    chk("tie_not_done", DMI_DONE_O, 0);
    DMI_RESP_I = {32'h55AA55AA, 2'b00};
    DMI_RESP_VALID_I = 1;
    tick();
    DMI_RESP_VALID_I = 0;
    chk("tie_done", DMI_DONE_O, 1);
    chk("tie_err", DMI_ERROR_O, 0);
    chk("tie_dmio", DMI_O, {7'h33, 2'b00, 32'h55AA55AA});
    DMI_READ_I = 0;
    tick();

    // Read+write together: write wins; DM answers failed
    DMI_I = {7'h05, 2'b00, 32'hA5A50000};
    DMI_RESP_I = {32'h0, 2'b10};
    DMI_RESP_VALID_I = 1;
    DMI_READ_I = 1; DMI_WRITE_I = 1;
    tick();
    chk("rw_reqo", DMI_REQ_O, {7'h05, 2'd2, 32'hA5A50000});
    tick(); tick();
    chk("rw_done", DMI_DONE_O, 1);
    chk("rw_err", DMI_ERROR_O, 2);
    chk("rw_dmio", DMI_O, {7'h05, 2'b10, 32'h0});
    DMI_READ_I = 0; DMI_WRITE_I = 0;
    tick();

    // Hard reset in RESP, held to show it blocks a new start
    DMI_RESP_VALID_I = 0;
    DMI_I = {7'h0A, 2'b00, 32'h0};
    DMI_READ_I = 1;
    tick(); tick();
    chk("hr_in_resp", DMI_RESP_READY_O, 1);
    DMI_HARD_RESET_I = 1;
    tick();
    chk_reset_state("hr");
    tick();
    chk("hr_block", DMI_REQ_VALID_O, 0);
    DMI_HARD_RESET_I = 0;
    DMI_REQ_READY_I = 0;
    tick();
    chk("hr_restart", DMI_REQ_VALID_O, 1);
    // Reset in REQ
    RST_I = 1;
    tick();
    chk_reset_state("rq");
    RST_I = 0; DMI_READ_I = 0;
    tick();

    // Normal read after the aborts
    DMI_REQ_READY_I = 1; DMI_RESP_VALID_I = 1;
    DMI_RESP_I = {32'h0BADF00D, 2'b00};
    DMI_I = {7'h11, 2'b00, 32'h0};
    DMI_READ_I = 1;
    tick(); tick();
    chk("post_not_done", DMI_DONE_O, 0);
    tick();
    chk("post_done", DMI_DONE_O, 1);
    chk("post_dmio", DMI_O, {7'h11, 2'b00, 32'h0BADF00D});
    DMI_READ_I = 0;
    tick();
    chk("post_idle", DMI_DONE_O, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dmi_handler.md
DMI_HANDLER -- requirements
Module: dmi_handler

Interface
REQ-001 Parameter ABITS, default 7, shall set the DMI address width.
REQ-002 Parameter TIMEOUT_CYCLES, default 1000, shall set the maximum cycles from request issue to response.
REQ-003 Request word layout (REQW = ABITS+34 = 41) shall be {addr[REQW-1:34], op[33:32], data[31:0]}; op 0 = nop, 1 = read, 2 = write.
REQ-004 Response word layout shall be {data[33:2], resp[1:0]}; resp 0 = ok, 2 = failed, 3 = busy.
REQ-005 CLK_I  in  1  single clock; all logic on its rising edge.
REQ-006 RST_I  in  1  reset, synchronous, active-high.
REQ-007 DMI_READ_I  in  1  TAP read request, held high until DMI_DONE_O is seen.
REQ-008 DMI_WRITE_I  in  1  TAP write request, held high until DMI_DONE_O is seen.
REQ-009 DMI_I  in  REQW  TAP request word.
REQ-010 DMI_O  out  REQW  result word returned to the TAP.
REQ-011 DMI_DONE_O  out  1  transaction complete.
REQ-012 DMI_HARD_RESET_I  in  1  dtmcs.dmihardreset; aborts any transaction.
REQ-013 DMI_ERROR_O  out  2  resp code of the last transaction.
REQ-014 DMI_REQ_VALID_O / DMI_REQ_READY_I  out/in  1/1  request handshake to the DM.
REQ-015 DMI_REQ_O  out  REQW  request word to the DM.
REQ-016 DMI_RESP_VALID_I / DMI_RESP_READY_O  in/out  1/1  response handshake from the DM.
REQ-017 DMI_RESP_I  in  34  response word from the DM.

Function
REQ-018 FSM states shall be IDLE, REQ, RESP and DONE.
REQ-019 IDLE: when DMI_WRITE_I=1, the handler shall latch {DMI_I.addr, op=2, DMI_I.data} and go to REQ.
- When only DMI_READ_I=1, it shall latch {DMI_I.addr, op=1, data=0} and go to REQ.
- When both are high, write shall win.
REQ-020 REQ: DMI_REQ_VALID_O=1 with DMI_REQ_O stable; on a cycle with DMI_REQ_READY_I=1 the FSM shall go to RESP.
- VALID shall not drop before acceptance, even if the TAP request is withdrawn.
REQ-021 RESP: DMI_RESP_READY_O=1; on DMI_RESP_VALID_I=1 the handler shall capture the response and go to DONE.
- DMI_O <= {latched addr, DMI_RESP_I.resp, DMI_RESP_I.data}.
- DMI_ERROR_O <= DMI_RESP_I.resp.
REQ-022 DONE: DMI_DONE_O=1 (Moore, registered state). The FSM shall return to IDLE on the first cycle where DMI_READ_I=0 and DMI_WRITE_I=0.
REQ-023 Minimum transaction latency shall be 4 cycles (IDLE to DONE) with READY and VALID tied high.
- Back-to-back requests shall require 1 IDLE cycle between transactions.
REQ-024 A timeout counter shall clear on entering REQ and increment in REQ and RESP.
- When it reaches TIMEOUT_CYCLES, the FSM shall go to DONE.
- DMI_ERROR_O shall be set to 3, and DMI_O shall be set to {latched addr, 2'b11, 32'h0}.
- REQ_VALID and RESP_READY shall drop.
REQ-025 The counter shall saturate and never wrap; its width shall be $clog2(TIMEOUT_CYCLES+1).
REQ-026 A response arriving in the same cycle as the timeout shall take priority (normal capture).
REQ-027 DMI_RESP_VALID_I outside RESP shall be ignored; DMI_REQ_READY_I outside REQ shall be ignored.
REQ-028 DMI_O and DMI_ERROR_O shall hold their values until the next capture or reset.
REQ-029 DMI_HARD_RESET_I=1 in any state shall force the reset state of REQ-030 on the next edge.
- It shall also block a new transaction start while high.

Reset
REQ-030 While RST_I=1 at a clock edge, the block shall enter the following reset state:
- state=IDLE, DMI_O=0, DMI_DONE_O=0, DMI_ERROR_O=0.
- DMI_REQ_VALID_O=0, DMI_REQ_O=0, DMI_RESP_READY_O=0, counter=0.
REQ-031 Reset mid-transaction shall abandon the DM handshake without completion; the first request after release shall start from IDLE.

Verification
REQ-032 Read, READY/VALID tied 1, DMI_I.addr=7'h11, DM data 32'hDEADBEEF, resp 0 -> DMI_REQ_O={11,1,0}; DONE on cycle 4; DMI_O={11,0,DEADBEEF}; ERROR 0.
REQ-033 Write addr 7'h10, data 32'h1 with DMI_REQ_READY_I delayed 5 cycles -> VALID held 6 cycles with a stable word; DONE after the response; DONE stays high until DMI_WRITE_I drops, then IDLE.
REQ-034 No response, TIMEOUT_CYCLES=16 -> DONE 16 cycles after entering REQ; ERROR=3; DMI_O.op=3; data 0.
REQ-035 Simultaneous read+write, then DM resp 2 -> request op=2; ERROR=2; DMI_O.op=2.
REQ-036 DMI_HARD_RESET_I pulsed in RESP, then RST_I pulsed in REQ -> outputs at reset values next cycle each time; next read completes normally.
